// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared sizing, tag type and round-robin pick for rom_arbiter.
// Widths are sized for the largest supported requester count so one tag type serves every configuration.
package rom_arbiter_pkg;

    localparam int MAX_REQ = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int IDX_W = clog2(MAX_REQ);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Walk from farthest to nearest so the first eligible index after last_grant wins.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] eligible,
        input logic [IDX_W-1:0]   last_grant,
        input int                 num_req
    );
        logic [MAX_REQ-1:0] pick;
        int j;
        pick = '0;
        for (int k = MAX_REQ; k > 0; k--) begin
            j = (int'(last_grant) + k) % num_req;
            if (k <= num_req && |(eligible & (MAX_REQ'(1) << j)))
                pick = MAX_REQ'(1) << j;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester request/response channels plus the shared ROM port.
interface rom_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0]            rsp_valid_o;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_o;
    logic [NUM_REQ-1:0]            rsp_ready_i;
    logic [ADDR_WIDTH-1:0]         rom_addr_o;
    logic [DATA_WIDTH-1:0]         rom_data_i;

    modport master (
        output req_valid_i, req_addr_i, rsp_ready_i, rom_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rom_addr_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, rsp_ready_i, rom_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rom_addr_o
    );
endinterface

// File: rtl/rom_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant (one-hot plus index) starting after last_grant.
module rr_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);
    logic [MAX_REQ-1:0] pick;

    assign pick  = rr_pick(MAX_REQ'(eligible), last_grant, NUM_REQ);
    assign grant = pick[NUM_REQ-1:0];

    always_comb begin
        idx = '0;
        for (int k = 0; k < MAX_REQ; k++)
            if (pick[k]) idx = IDX_W'(k);
    end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one registered-output ROM among NUM_REQ requesters,
// one read outstanding per requester, responses routed back by a tag pipeline.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic         clk_i,
    input  logic         arstn_i,
    rom_arbiter_if.slave bus
);
    localparam int L = ROM_LATENCY;

    logic [NUM_REQ-1:0] busy, grant, hs, rsp_acc;
    logic [IDX_W-1:0]   idx, last_grant;
    tag_t               pipe [L+1];
    tag_t               ex;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .eligible   (bus.req_valid_i & ~busy),
        .last_grant (last_grant),
        .grant      (grant),
        .idx        (idx)
    );

    // Gating with reset keeps ready low while held in reset, even with requests pending.
    assign bus.req_ready_o = grant & {NUM_REQ{arstn_i}};
    assign hs              = bus.req_valid_i & bus.req_ready_o;
    assign rsp_acc         = bus.rsp_valid_o & bus.rsp_ready_i;
    assign ex              = pipe[L];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            busy            <= '0;
            last_grant      <= IDX_W'(NUM_REQ - 1);
            bus.rom_addr_o  <= '0;
            bus.rsp_valid_o <= '0;
            bus.rsp_data_o  <= '0;
            for (int k = 0; k <= L; k++) pipe[k] <= '0;
        end else begin
            busy <= (busy | hs) & ~rsp_acc;
            if (|hs) begin
                bus.rom_addr_o <= bus.req_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
                last_grant     <= idx;
            end
            pipe[0] <= '{valid: |hs, idx: idx};
            for (int k = 1; k <= L; k++) pipe[k] <= pipe[k-1];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ex.valid && ex.idx == IDX_W'(i)) begin
                    bus.rsp_valid_o[i]                          <= 1'b1;
                    bus.rsp_data_o[i*DATA_WIDTH +: DATA_WIDTH] <= bus.rom_data_i;
                end else if (rsp_acc[i]) begin
                    bus.rsp_valid_o[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed vectors against rom_arbiter driving a one-cycle ROM holding a ^ 8'hA5.
module tb_rom_arbiter;
    logic clk = 1'b0;
    logic arstn;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] mem [256];
    logic [7:0] exp_d [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
    logic [3:0] exp_f [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
    logic [3:0] seen  [4];
    int   ng;

    rom_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    rom_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .ROM_LATENCY(1)) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hA5;

    always @(posedge clk) bus.rom_data_i <= mem[bus.rom_addr_o];

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        arstn = 1'b0;
        bus.req_valid_i = '0;
        tick;
        tick;
        arstn = 1'b1;
    endtask

    initial begin
        arstn = 1'b0;
        bus.req_valid_i = 4'b1111;
        bus.req_addr_i  = '0;
        bus.rsp_ready_i = 4'b1111;
        tick;
        tick;
        check("rst_ready", 32'(bus.req_ready_o), 32'h0);
        check("rst_rsp_v", 32'(bus.rsp_valid_o), 32'h0);
        check("rst_rsp_d", 32'(bus.rsp_data_o), 32'h0);
        check("rst_addr",  32'(bus.rom_addr_o), 32'h0);
        bus.req_valid_i = '0;
        arstn = 1'b1;
        tick;

        // single request from requester 0
        bus.req_addr_i  = 32'h0000_0010;
        bus.req_valid_i = 4'b0001;
        #1 check("single_ready", 32'(bus.req_ready_o), 32'h1);
        tick;
        bus.req_valid_i = '0;
        check("single_addr", 32'(bus.rom_addr_o), 32'h10);
        check("single_v1", 32'(bus.rsp_valid_o), 32'h0);
        tick;
        check("single_v2", 32'(bus.rsp_valid_o), 32'h0);
        tick;
        check("single_v3", 32'(bus.rsp_valid_o), 32'h1);
        check("single_d",  32'(bus.rsp_data_o[7:0]), 32'hB5);
        tick;
        check("single_clr", 32'(bus.rsp_valid_o), 32'h0);

        // fairness between 0 and 2 after last grant went to 0
        for (int i = 0; i < 4; i++) seen[i] = '0;
        ng = 0;
        bus.req_valid_i = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.req_ready_o != 0 && ng < 4) begin
                seen[ng] = bus.req_ready_o;
                ng++;
            end
            tick;
        end
        bus.req_valid_i = '0;
        for (int i = 0; i < 4; i++) check("fair_order", 32'(seen[i]), 32'(exp_f[i]));
        repeat (6) tick;

        // all four requesting back-to-back
        do_reset;
        bus.req_addr_i  = 32'h0302_0100;
        bus.req_valid_i = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) bus.req_valid_i = '0;
            #1 check("rr_grant", 32'(bus.req_ready_o), (k < 4) ? (32'h1 << k) : 32'h0);
            tick;
            if (k >= 2) begin
                check("rr_rsp_v", 32'(bus.rsp_valid_o), 32'h1 << (k - 2));
                check("rr_rsp_d", 32'(bus.rsp_data_o[(k-2)*8 +: 8]), 32'(exp_d[k-2]));
            end
        end
        tick;
        tick;

        // backpressure on requester 1
        bus.req_addr_i  = 32'h0000_2000;
        bus.rsp_ready_i = 4'b1101;
        bus.req_valid_i = 4'b0010;
        #1 check("bp_ready", 32'(bus.req_ready_o), 32'h2);
        tick;
        for (int c = 0; c < 7; c++) begin
            check("bp_busy", 32'(bus.req_ready_o), 32'h0);
            if (c >= 2) begin
                check("bp_hold_v", 32'(bus.rsp_valid_o), 32'h2);
                check("bp_hold_d", 32'(bus.rsp_data_o[15:8]), 32'h85);
            end
            tick;
        end
        bus.rsp_ready_i = 4'b1111;
        #1 check("bp_acc_cycle", 32'(bus.req_ready_o), 32'h0);
        tick;
        check("bp_rsp_clr", 32'(bus.rsp_valid_o), 32'h0);
        check("bp_regrant", 32'(bus.req_ready_o), 32'h2);
        bus.req_valid_i = '0;
        tick;

        // reset while requester 3 is in flight
        bus.req_addr_i  = 32'h3300_0000;
        bus.req_valid_i = 4'b1000;
        #1 check("mid_ready", 32'(bus.req_ready_o), 32'h8);
        tick;
        bus.req_valid_i = '0;
        check("mid_addr", 32'(bus.rom_addr_o), 32'h33);
        tick;
        arstn = 1'b0;
        bus.req_valid_i = 4'b1001;
        #1;
        check("mid_rsp_v", 32'(bus.rsp_valid_o), 32'h0);
        check("mid_rsp_d", 32'(bus.rsp_data_o), 32'h0);
        check("mid_addr0", 32'(bus.rom_addr_o), 32'h0);
        check("mid_ready0", 32'(bus.req_ready_o), 32'h0);
        tick;
        arstn = 1'b1;
        #1 check("mid_prio0", 32'(bus.req_ready_o), 32'h1);
        bus.req_valid_i = '0;
        for (int c = 0; c < 4; c++) begin
            tick;
            check("mid_no_rsp", 32'(bus.rsp_valid_o), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
